// File: rtl/mul_datapath_if.sv
// Operand bus and control/status bundle between the multiplier controller and its datapath.
// The controller drives data_in and the load/step strobes; the datapath returns eqz, product and debug status.
interface mul_datapath_if #(
   parameter int W  = 16,
   parameter int PW = 2*W,
   parameter int CW = 8
);
   logic [W-1:0]  data_in;
   logic          ldA;
   logic          ldB;
   logic          ldP;
   logic          clrP;
   logic          decQ;
   logic          eqz;
   logic [PW-1:0] product;
   logic [CW-1:0] iter_cnt;
   logic          err_proto;
   logic [2:0]    err_code;

   modport master (
      output data_in, ldA, ldB, ldP, clrP, decQ,
      input  eqz, product, iter_cnt, err_proto, err_code
   );

   modport slave (
      input  data_in, ldA, ldB, ldP, clrP, decQ,
      output eqz, product, iter_cnt, err_proto, err_code
   );
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: A, down-counting B, accumulator P, iteration count, protocol checker.
// One-cycle latency from control sample to visible result; no backpressure, every strobe is acted on.
module mul_datapath #(
   parameter int W  = 16,
   parameter int PW = 2*W,   // must be >= 2*W so A*B never overflows P
   parameter int CW = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   mul_datapath_if.slave bus
);

   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_LDAB    = 3'd1,
      ERR_PCLR    = 3'd2,
      ERR_UNDER   = 3'd3,
      ERR_LDB_RUN = 3'd4
   } err_code_t;

   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [PW-1:0] p_q;
   logic [CW-1:0] cnt_q;
   logic          err_q;
   err_code_t     code_q;

   logic          b_zero;
   logic [PW-1:0] a_ext;
   logic          cnt_sat;
   err_code_t     code_now;

   assign b_zero  = (b_q == '0);
   assign a_ext   = {{(PW-W){1'b0}}, a_q};
   assign cnt_sat = &cnt_q;

   // Lowest code wins when several violations coincide.
   always_comb begin
      code_now = ERR_NONE;
      if (bus.ldA && bus.ldB)
         code_now = ERR_LDAB;
      else if (bus.ldP && bus.clrP)
         code_now = ERR_PCLR;
      else if (bus.decQ && b_zero && !bus.ldB)
         code_now = ERR_UNDER;
      else if (bus.ldB && (bus.ldP || bus.decQ))
         code_now = ERR_LDB_RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         code_q <= ERR_NONE;
      end else begin
         if (bus.ldA)
            a_q <= bus.data_in;

         // B never wraps below zero; the underflow is reported instead.
         if (bus.ldB)
            b_q <= bus.data_in;
         else if (bus.decQ && !b_zero)
            b_q <= b_q - 1'b1;

         // Accumulate uses the pre-edge A, so ldA+ldP adds the old operand.
         if (bus.clrP) begin
            p_q   <= '0;
            cnt_q <= '0;
         end else if (bus.ldP) begin
            p_q <= p_q + a_ext;
            if (!cnt_sat)
               cnt_q <= cnt_q + 1'b1;
         end

         if (!err_q && (code_now != ERR_NONE)) begin
            err_q  <= 1'b1;
            code_q <= code_now;
         end
      end
   end

   assign bus.eqz       = b_zero;
   assign bus.product   = p_q;
   assign bus.iter_cnt  = cnt_q;
   assign bus.err_proto = err_q;
   assign bus.err_code  = code_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath: table of cycle vectors plus model-driven multiply sequences through a scoreboard queue.
module tb_mul_datapath;
   localparam int W = 16, PW = 32, CW = 8;
   localparam logic [4:0] C_LDA = 5'b10000, C_LDB = 5'b01000, C_LDP = 5'b00100,
                          C_CLR = 5'b00010, C_DEC = 5'b00001, C_NONE = 5'b00000;

   typedef struct packed {
      logic [31:0] p;
      logic        eqz;
      logic [7:0]  cnt;
      logic        ep;
      logic [2:0]  ec;
   } exp_t;

   typedef struct packed {
      logic [4:0]  ctl;
      logic [15:0] din;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_datapath_if #(.W(W), .PW(PW), .CW(CW)) bus ();

   mul_datapath #(.W(W), .PW(PW), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_vec = 0;
   int   n_err = 0;
   bit   quiet = 1'b0;
   exp_t sb[$];

   // Reference state
   logic [15:0] m_a, m_b;
   logic [31:0] m_p;
   logic [7:0]  m_cnt;
   logic        m_ep;
   logic [2:0]  m_ec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [4:0] c, input logic [15:0] d);
      bus.ldA = c[4]; bus.ldB = c[3]; bus.ldP = c[2]; bus.clrP = c[1]; bus.decQ = c[0];
      bus.data_in = d;
   endtask

   // Drive one cycle at negedge, queue its expectation, compare one cycle later.
   task automatic apply(input logic [4:0] c, input logic [15:0] d, input exp_t e);
      exp_t got;
      drive(c, d);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drive(C_NONE, 16'h0);
      got = sb.pop_front();
      if (!quiet) begin
         chk("eqz",       {31'b0, bus.eqz},      {31'b0, got.eqz});
         chk("product",   bus.product,           got.p);
         chk("iter_cnt",  {24'b0, bus.iter_cnt}, {24'b0, got.cnt});
         chk("err_proto", {31'b0, bus.err_proto},{31'b0, got.ep});
         chk("err_code",  {29'b0, bus.err_code}, {29'b0, got.ec});
      end
   endtask

   task automatic mstep(input logic [4:0] c, input logic [15:0] d);
      logic       lda, ldb, ldp, clr, dec;
      logic [2:0] code;
      exp_t       e;
      {lda, ldb, ldp, clr, dec} = c;
      code = 3'd0;
      if (lda && ldb)                    code = 3'd1;
      else if (ldp && clr)               code = 3'd2;
      else if (dec && m_b == 0 && !ldb)  code = 3'd3;
      else if (ldb && (ldp || dec))      code = 3'd4;
      if (!m_ep && code != 0) begin m_ep = 1'b1; m_ec = code; end
      if (clr) begin m_p = 0; m_cnt = 0; end
      else if (ldp) begin
         m_p = m_p + {16'b0, m_a};
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
      end
      if (ldb) m_b = d;
      else if (dec && m_b != 0) m_b = m_b - 1;
      if (lda) m_a = d;
      e = '{p: m_p, eqz: (m_b == 0), cnt: m_cnt, ep: m_ep, ec: m_ec};
      apply(c, d, e);
   endtask

   task automatic chk_zero_state(input string tag);
      chk({tag, ".eqz"},       {31'b0, bus.eqz},       32'd1);
      chk({tag, ".product"},   bus.product,            32'd0);
      chk({tag, ".iter_cnt"},  {24'b0, bus.iter_cnt},  32'd0);
      chk({tag, ".err_proto"}, {31'b0, bus.err_proto}, 32'd0);
      chk({tag, ".err_code"},  {29'b0, bus.err_code},  32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      repeat (2) begin
         drive(5'($urandom_range(0, 31)), 16'($urandom));
         @(posedge clk);
         @(negedge clk);
      end
      drive(C_NONE, 16'h0);
      m_a = 0; m_b = 0; m_p = 0; m_cnt = 0; m_ep = 0; m_ec = 0;
      chk_zero_state(tag);
      rst_n = 1'b1;
   endtask

   // Controller loop: ldP+decQ until eqz, bounded.
   task automatic run_loop(input int budget, output int steps);
      steps = 0;
      while (!bus.eqz && steps < budget) begin
         mstep(C_LDP | C_DEC, 16'h0);
         steps++;
      end
      if (steps >= budget) chk("loop_budget", 32'(steps), 32'(budget - 1));
   endtask

   vec_t tbl[11];
   int   steps;

   initial begin
      tbl[0]  = '{C_LDA,         16'd10, '{32'd0,  1'b1, 8'd0, 1'b0, 3'd0}};
      tbl[1]  = '{C_LDA | C_LDP, 16'd3,  '{32'd10, 1'b1, 8'd1, 1'b0, 3'd0}};
      tbl[2]  = '{C_LDP,         16'd0,  '{32'd13, 1'b1, 8'd2, 1'b0, 3'd0}};
      tbl[3]  = '{C_LDA,         16'd27, '{32'd13, 1'b1, 8'd2, 1'b0, 3'd0}};
      tbl[4]  = '{C_LDP,         16'd0,  '{32'd40, 1'b1, 8'd3, 1'b0, 3'd0}};
      tbl[5]  = '{C_LDP | C_CLR, 16'd0,  '{32'd0,  1'b1, 8'd0, 1'b1, 3'd2}};
      tbl[6]  = '{C_LDA | C_LDB, 16'd9,  '{32'd0,  1'b0, 8'd0, 1'b1, 3'd2}};
      tbl[7]  = '{C_LDP,         16'd0,  '{32'd9,  1'b0, 8'd1, 1'b1, 3'd2}};
      tbl[8]  = '{C_DEC,         16'd0,  '{32'd9,  1'b0, 8'd1, 1'b1, 3'd2}};
      tbl[9]  = '{C_LDB | C_DEC, 16'd0,  '{32'd9,  1'b1, 8'd1, 1'b1, 3'd2}};
      tbl[10] = '{C_DEC,         16'd0,  '{32'd9,  1'b1, 8'd1, 1'b1, 3'd2}};

      drive(C_NONE, 16'h0);
      @(negedge clk);

      do_reset("reset");
      foreach (tbl[i]) apply(tbl[i].ctl, tbl[i].din, tbl[i].e);

      // Nominal 17 x 5
      do_reset("reset2");
      mstep(C_LDA, 16'd17);
      mstep(C_LDB | C_CLR, 16'd5);
      run_loop(20, steps);
      chk("nom.steps", 32'(steps), 32'd5);
      chk("nom.product", bus.product, 32'd85);
      chk("nom.iter_cnt", {24'b0, bus.iter_cnt}, 32'd5);
      chk("nom.err_proto", {31'b0, bus.err_proto}, 32'd0);

      // Full-scale operands, per-cycle compares suppressed for the long loop
      do_reset("reset3");
      mstep(C_LDA, 16'hFFFF);
      mstep(C_LDB | C_CLR, 16'hFFFF);
      quiet = 1'b1;
      run_loop(70000, steps);
      quiet = 1'b0;
      chk("max.steps", 32'(steps), 32'd65535);
      chk("max.product", bus.product, 32'hFFFE0001);
      chk("max.iter_cnt", {24'b0, bus.iter_cnt}, 32'd255);
      chk("max.err_proto", {31'b0, bus.err_proto}, 32'd0);

      // B_initial = 0
      mstep(C_LDB | C_CLR, 16'd0);
      chk("b0.eqz", {31'b0, bus.eqz}, 32'd1);
      chk("b0.product", bus.product, 32'd0);

      // Underflow
      do_reset("reset4");
      mstep(C_LDB, 16'd1);
      mstep(C_DEC, 16'd0);
      chk("uf1.err_proto", {31'b0, bus.err_proto}, 32'd0);
      mstep(C_DEC, 16'd0);
      chk("uf2.eqz", {31'b0, bus.eqz}, 32'd1);
      chk("uf2.err_proto", {31'b0, bus.err_proto}, 32'd1);
      chk("uf2.err_code", {29'b0, bus.err_code}, 32'd3);

      // Codes 1 and 4 together: lowest wins
      do_reset("reset5");
      mstep(C_LDA | C_LDB | C_LDP, 16'd6);
      chk("prio.err_code", {29'b0, bus.err_code}, 32'd1);
      do_reset("reset6");
      mstep(C_LDB | C_DEC, 16'd2);
      chk("ldbrun.err_code", {29'b0, bus.err_code}, 32'd4);

      // Reset mid-loop, then fresh 3 x 4
      do_reset("reset7");
      mstep(C_LDA, 16'd5);
      mstep(C_LDB | C_CLR, 16'd7);
      repeat (3) mstep(C_LDP | C_DEC, 16'h0);
      chk("mid.product", bus.product, 32'd15);
      rst_n = 1'b0;
      drive(C_LDP | C_DEC, 16'h0);
      @(posedge clk);
      @(negedge clk);
      drive(C_NONE, 16'h0);
      rst_n = 1'b1;
      m_a = 0; m_b = 0; m_p = 0; m_cnt = 0; m_ep = 0; m_ec = 0;
      chk_zero_state("midrst");
      mstep(C_LDA, 16'd3);
      mstep(C_LDB | C_CLR, 16'd4);
      run_loop(20, steps);
      chk("post.product", bus.product, 32'd12);
      chk("post.iter_cnt", {24'b0, bus.iter_cnt}, 32'd4);
      chk("post.err_proto", {31'b0, bus.err_proto}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mul_datapath.md
Name: mul_datapath

Overview:
- Datapath for the repeated-addition multiplier. It is the responder to the multiplier controller: it consumes ldA, ldB, ldP, clrP and decQ, and returns eqz.
- Holds multiplicand A, a down-counting multiplier B, and accumulator P. All three load from one shared data_in bus.
- Adds protocol-error detection and a debug iteration count so a bench or top level can check the controller's sequencing.

Parameters:
- W, 16, width of data_in, A and B.
- PW, 2*W, width of accumulator P and of product. Must be at least 2*W, so the product can never overflow.
- CW, 8, width of the iteration counter iter_cnt. It saturates at 2^CW-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- data_in  in  W  shared operand bus, sampled on ldA or ldB
- ldA  in  1  load A from data_in
- ldB  in  1  load B from data_in
- ldP  in  1  accumulate: P <= P + A
- clrP  in  1  clear P
- decQ  in  1  decrement B
- eqz  out  1  B == 0, combinational from the B register
- product  out  PW  current P register value
- iter_cnt  out  CW  number of accepted ldP accumulates since the last clrP
- err_proto  out  1  sticky protocol-error flag
- err_code  out  3  first error latched: 1=ldA&ldB, 2=ldP&clrP, 3=decQ at B==0, 4=ldB while ldP/decQ active; 0 = none

Behaviour:
- Reset: rst_n sampled low at posedge clears A, B, P, iter_cnt, err_proto and err_code to 0. eqz then reads 1 and product reads 0. Reset mid-operation aborts everything, with no partial update that cycle.
- All registers update on posedge clk only. No control input has any combinational effect except eqz, which follows B.
- A register: ldA=1 loads data_in; otherwise A holds. A is unchanged by all other controls.
- B register, in priority order:
  - ldB=1 loads data_in.
  - else decQ=1 and B!=0: B <= B-1.
  - else decQ=1 and B==0: B stays 0 (no wrap to all-ones); error code 3.
  - else B holds.
- P register, in priority order:
  - clrP=1: P <= 0 and iter_cnt <= 0.
  - else ldP=1: P <= P + zero_extend(A), modulo 2^PW; iter_cnt <= iter_cnt+1, saturating.
  - else P holds.
- Accumulate uses the A value registered before the edge. If ldA and ldP are asserted together, the old A is added and the new A becomes visible the next cycle.
- ldP and decQ together in one cycle is the normal loop step. Both take effect on the same edge, and eqz reflects the decremented B the following cycle.
- Latency: a load or accumulate is visible on product, eqz or iter_cnt one cycle after the edge that samples the control.
- Error detection, evaluated every cycle out of reset:
  - code 1: ldA & ldB.
  - code 2: ldP & clrP.
  - code 3: decQ & (B==0) & !ldB.
  - code 4: ldB & (ldP | decQ).
  - On the first detected error, err_proto <= 1 and err_code <= that code. Lowest code wins when several fire in the same cycle.
  - Later errors do not overwrite the latched code. Only reset clears err_proto and err_code.
  - Errors never block the register updates defined above. With ldA & ldB, both registers load data_in.
- Completion: a correct sequence (ldA; ldB+clrP; then ldP+decQ repeated until eqz) leaves product = A*B_initial and iter_cnt = B_initial. This holds when B_initial is less than 2^CW.
- B_initial = 0: eqz is high immediately after the ldB edge, the controller issues no accumulates, and product = 0.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with random controls toggling -> A=B=P=0, eqz=1, product=0, iter_cnt=0, err_proto=0, err_code=0.
- Nominal multiply, W=16: ldA with 17, ldB+clrP with 5, then ldP+decQ until eqz -> eqz rises after exactly 5 steps, product=85, iter_cnt=5, err_proto=0.
- Boundaries:
  - A=0xFFFF, B=0xFFFF run to completion -> product=0xFFFE0001, no error, iter_cnt saturated at 255.
  - B=0 -> eqz=1 the cycle after load, product=0.
- Underflow: load B=1, then decQ on 2 consecutive cycles -> B=0 then stays 0, err_proto=1, err_code=3.
- Collisions:
  - ldP and clrP in the same cycle with P=40 -> P=0, err_code=2.
  - Then ldA and ldB together with data_in=9 -> A=B=9, err_code remains 2 (sticky first error).
- Reset mid-loop: assert rst_n=0 after 3 of 7 accumulates -> all registers 0 next cycle. A fresh 3x4 run afterwards gives product=12, iter_cnt=4.
